// File: rtl/monitor_sequencia.sv
// monitor_sequencia: follows the 16-step counter sequence
// 1,3,5,0,2,4,6,7,8,9,10,15,14,13,12,11, locks after LOCK_N consecutive
// correct transitions, flags each out-of-order step while locked, and keeps
// saturating error and wrapping lap counters for the LEDs / 7-segment display.
//
// Handshake: count is consumed on every rising clk edge where count_valid=1
// and rst_n=1; there is no back-pressure. All outputs are registered and show
// the result of a sample one edge after it is taken. While count_valid=0
// everything holds except error, which returns to 0.
module monitor_sequencia #(
    parameter int LOCK_N = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] count,
    input  logic       count_valid,
    output logic       locked,
    output logic       error,
    output logic [7:0] err_count,
    output logic [7:0] lap_count,
    output logic [3:0] position,
    output logic [3:0] expected,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] LOCK_TARGET = 5'(LOCK_N);

    state_t     state;
    logic [3:0] prev;
    logic [3:0] match_cnt;
    logic       step_ok;

    // Successor of a code in the counter sequence.
    function automatic logic [3:0] succ_of(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'd1:    s = 4'd3;
            4'd3:    s = 4'd5;
            4'd5:    s = 4'd0;
            4'd0:    s = 4'd2;
            4'd2:    s = 4'd4;
            4'd4:    s = 4'd6;
            4'd6:    s = 4'd7;
            4'd7:    s = 4'd8;
            4'd8:    s = 4'd9;
            4'd9:    s = 4'd10;
            4'd10:   s = 4'd15;
            4'd15:   s = 4'd14;
            4'd14:   s = 4'd13;
            4'd13:   s = 4'd12;
            4'd12:   s = 4'd11;
            default: s = 4'd1;   // 11 wraps back to 1
        endcase
        return s;
    endfunction

    // Position of a code within the sequence (1 is index 0, 11 is index 15).
    function automatic logic [3:0] index_of(input logic [3:0] v);
        logic [3:0] i;
        case (v)
            4'd1:    i = 4'd0;
            4'd3:    i = 4'd1;
            4'd5:    i = 4'd2;
            4'd0:    i = 4'd3;
            4'd2:    i = 4'd4;
            4'd4:    i = 4'd5;
            4'd6:    i = 4'd6;
            4'd7:    i = 4'd7;
            4'd8:    i = 4'd8;
            4'd9:    i = 4'd9;
            4'd10:   i = 4'd10;
            4'd15:   i = 4'd11;
            4'd14:   i = 4'd12;
            4'd13:   i = 4'd13;
            4'd12:   i = 4'd14;
            default: i = 4'd15;  // 11
        endcase
        return i;
    endfunction

    // Does the incoming sample follow the last accepted one.
    always_comb begin
        step_ok = (count == succ_of(prev));
    end

    assign state_dbg = state;

    // Sequence FSM with all status outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            prev      <= 4'd1;
            match_cnt <= 4'd0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= 8'd0;
            lap_count <= 8'd0;
            position  <= 4'd0;
            expected  <= 4'd3;
        end else begin
            error <= 1'b0;
            if (count_valid) begin
                prev     <= count;
                position <= index_of(count);
                expected <= succ_of(count);
                unique case (state)
                    HUNT: begin
                        state     <= TRACK;
                        match_cnt <= 4'd0;
                    end
                    TRACK: begin
                        if (step_ok) begin
                            if (({1'b0, match_cnt} + 5'd1) == LOCK_TARGET) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= 4'd0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            // Resync from the new value, silently.
                            match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (step_ok) begin
                            if (prev == 4'd11 && count == 4'd1) begin
                                lap_count <= lap_count + 8'd1;
                            end
                        end else begin
                            error     <= 1'b1;
                            locked    <= 1'b0;
                            state     <= TRACK;
                            match_cnt <= 4'd0;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        match_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
